// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and default width for the ALU sequencer slice.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_MOD = 4'h4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command and response valid/ready channels of the ALU sequencer.
interface alu_sequencer_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic               cmd_valid;
    logic               cmd_ready;
    logic [3:0]         cmd_op;
    logic               cmd_load;
    logic [WIDTH-1:0]   cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*WIDTH-1:0] rsp_result;
    logic               rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_load, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_load, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_err
    );

endinterface

// File: rtl/seq_settle_cnt.sv
// 4-bit settle down-counter: loaded on issue, decremented while enabled, done at zero.
module seq_settle_cnt
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Accumulator-based command sequencer driving a combinational ALU with a settle delay.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    alu_sequencer_if.slave     bus,
    output logic [WIDTH-1:0]   alu_in1,
    output logic [WIDTH-1:0]   alu_in2,
    output logic [3:0]         alu_op,
    input  logic [2*WIDTH-1:0] alu_out,
    input  logic               alu_err,
    output logic [WIDTH-1:0]   acc,
    output logic               err_sticky
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t state;
    logic   accept;
    logic   settle_done;

    assign accept = bus.cmd_valid && bus.cmd_ready;

    seq_settle_cnt u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && !bus.cmd_load),
        .load_val (SETTLE_LOAD),
        .dec      (state == ISSUE),
        .done     (settle_done)
    );

    // cmd_ready/rsp_valid are registered copies of the state decode, so they
    // are updated alongside every state transition below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.cmd_ready  <= '0;
            bus.rsp_valid  <= '0;
            bus.rsp_result <= '0;
            bus.rsp_err    <= '0;
            alu_in1        <= '0;
            alu_in2        <= '0;
            alu_op         <= '0;
            acc            <= '0;
            err_sticky     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.cmd_ready <= '0;
                        if (bus.cmd_load) begin
                            acc            <= bus.cmd_data;
                            err_sticky     <= '0;
                            bus.rsp_result <= {{WIDTH{1'b0}}, bus.cmd_data};
                            bus.rsp_err    <= '0;
                            bus.rsp_valid  <= '1;
                            state          <= RESP;
                        end else begin
                            alu_in1 <= acc;
                            alu_in2 <= bus.cmd_data;
                            alu_op  <= bus.cmd_op;
                            state   <= ISSUE;
                        end
                    end else begin
                        bus.cmd_ready <= '1;
                    end
                end
                ISSUE: begin
                    if (settle_done) begin
                        bus.rsp_result <= alu_out;
                        bus.rsp_err    <= alu_err;
                        if (alu_err) begin
                            err_sticky <= '1;
                        end else begin
                            acc <= alu_out[WIDTH-1:0];
                        end
                        bus.rsp_valid <= '1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= '0;
                        bus.cmd_ready <= '1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.cmd_ready <= '0;
                    bus.rsp_valid <= '0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
